ysyx_25030093_pcu: RTL and testbench
====================================

YSYX_25030093_PCU -- requirements
Module: ysyx_25030093_PCU

Interface
REQ-001 Parameter: RESET_PC, 32'h8000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-004 pc  output  32  address of the instruction to fetch, driven to the fetch stage.
REQ-005 pc_valid  output  1  pc is valid and offered to the fetch stage.
REQ-006 ifu_ready  input  1  fetch stage accepts pc this cycle.
REQ-007 wbu_valid  input  1  writeback reports the current instruction retired.
REQ-008 wbu_ready  output  1  PCU accepts a retire report this cycle.
REQ-009 wbu_jump  input  1  retired instruction redirects control flow.
REQ-010 wbu_dnpc  input  32  redirect target; used only when wbu_jump=1.
REQ-011 exc_misalign  output  1  sticky: a computed next PC had bits [1:0] != 0.
REQ-012 retire_cnt  output  64  retired-instruction count; present only under REQ-030.

Function
REQ-013 States: ISSUE, WAIT, HALT; the encoding is internal.
- pc_valid=1 only in ISSUE.
- wbu_ready=1 only in WAIT.
REQ-014 ISSUE transitions:
- pc_valid & ifu_ready -> WAIT in the next cycle.
- Otherwise stay in ISSUE, with pc held stable.
REQ-015 WAIT with wbu_valid=1:
- next = wbu_jump ? wbu_dnpc : pc+4.
- If next[1:0]==0: pc<=next, go to ISSUE.
- Otherwise: go to HALT, set exc_misalign=1, leave pc unchanged.
REQ-016 WAIT with wbu_valid=0: stay in WAIT, pc unchanged.
REQ-017 pc+4 is computed modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-018 HALT is absorbing until reset:
- pc_valid=0, wbu_ready=0.
- exc_misalign stays 1.
- All inputs are ignored.
REQ-019 wbu_valid asserted in ISSUE or HALT is ignored; it causes no state or pc change.
REQ-020 ifu_ready asserted in WAIT or HALT is ignored.
REQ-021 Latency:
- Retire accepted at edge N -> pc_valid=1 with the new pc in cycle N+1.
- Fetch handshake at edge M -> wbu_ready=1 in cycle M+1.
REQ-022 At most one pc is outstanding between issue and retire; no second pc_valid before a retire is accepted.
REQ-023 pc, pc_valid and exc_misalign are driven directly from registers, with no combinational path from inputs.
REQ-024 wbu_ready is a function of state only.

Reset
REQ-025 rst=0 asynchronously forces:
- state=ISSUE, pc=RESET_PC, exc_misalign=0.
- retire_cnt=0 when present.
REQ-026 While rst=0: pc_valid=1 and wbu_ready=0, so the fetch stage sees a valid RESET_PC from the first cycle after reset.
REQ-027 Reset asserted mid-operation in WAIT or HALT discards the in-flight instruction; no retire is counted.
REQ-028 Deassertion of rst is synchronised internally; the first state change occurs no earlier than the second rising clk edge after rst rises.
REQ-029 RESET_PC with bits [1:0] != 0 is a configuration error and is not checked in hardware.

Configuration
REQ-030 PCU_PERF_CNT_EN defined:
- retire_cnt exists and increments by 1 on every accepted retire (wbu_valid & wbu_ready), including one that enters HALT.
- It wraps modulo 2^64 and is frozen in HALT.
REQ-031 PCU_PERF_CNT_EN undefined: the retire_cnt port and its counter logic are absent; all other behaviour is identical.

Verification
REQ-032 Reset, then ifu_ready=1 on the first cycle -> pc=32'h8000_0000 with pc_valid=1; the next cycle is WAIT with wbu_ready=1.
REQ-033 Sequential flow: three retires with wbu_jump=0 -> pc sequence 8000_0000, 8000_0004, 8000_0008, 8000_000C; retire_cnt=3 (macro on).
REQ-034 Redirect: retire with wbu_jump=1, wbu_dnpc=32'h8000_0100 -> next pc_valid cycle shows 8000_0100; wbu_dnpc is ignored when wbu_jump=0.
REQ-035 Misaligned redirect:
- Stimulus: wbu_dnpc=32'h8000_0102, wbu_jump=1.
- Response: HALT, exc_misalign=1, pc_valid=0.
- Further wbu_valid/ifu_ready cause no change.
- rst=0 clears everything.
REQ-036 Wrap: RESET_PC=32'hFFFF_FFFC, retire with wbu_jump=0 -> pc=32'h0000_0000, exc_misalign=0.
REQ-037 Protocol abuse:
- wbu_valid=1 held through ISSUE -> no pc change.
- ifu_ready held low 5 cycles -> pc stable, pc_valid stays 1.
- Reset asserted during WAIT -> pc returns to RESET_PC asynchronously.

Source files
------------

// File: rtl/ysyx_25030093_pcu.sv
// ysyx_25030093_pcu -- program counter unit
//
// Issues one PC at a time to the fetch stage. It then waits for writeback
// to retire that instruction before it computes and issues the next PC.
// A misaligned next PC (bits [1:0] != 0) parks the unit in HALT. The unit
// stays there, with a sticky exception flag, until reset.
//
// Ports:
//   clk_i            clock, all state changes on the rising edge
//   rst_ni           asynchronous active-low reset (deassertion synchronised)
//   pc_o             address offered to fetch
//   pc_valid_o       pc_o is valid (ISSUE state)
//   ifu_ready_i      fetch accepts pc_o this cycle
//   wbu_valid_i      writeback reports a retired instruction
//   wbu_ready_o      PCU accepts a retire report (WAIT state)
//   wbu_jump_i       retired instruction redirects control flow
//   wbu_dnpc_i       redirect target, used only when wbu_jump_i=1
//   exc_misalign_o   sticky misaligned-next-PC flag
//   retire_cnt_o     64-bit retired-instruction counter
//                    (only when PCU_PERF_CNT_EN is defined)
//
// Configuration macro: PCU_PERF_CNT_EN (adds retire_cnt_o and its counter).

module ysyx_25030093_pcu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  input  logic        ifu_ready_i,
  input  logic        wbu_valid_i,
  output logic        wbu_ready_o,
  input  logic        wbu_jump_i,
  input  logic [31:0] wbu_dnpc_i,
  output logic        exc_misalign_o
`ifdef PCU_PERF_CNT_EN
  ,
  output logic [63:0] retire_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pcValid_q, pcValid_d;
  logic        excMisalign_q, excMisalign_d;
  logic [1:0]  rstSync_q;
  logic        rstSyncN;
  logic        fetchFire;
  logic        retireFire;
  logic [31:0] nextPc;
  logic        nextMisaligned;

  // Reset asserts immediately but releases only after two clock edges,
  // so a release close to a clock edge cannot put the FSM in a mixed state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstSyncN = rstSync_q[1];

  assign fetchFire      = (state_q == ISSUE) && ifu_ready_i;
  assign retireFire     = (state_q == WAIT) && wbu_valid_i;
  assign nextPc         = wbu_jump_i ? wbu_dnpc_i : (pc_q + 32'd4);
  assign nextMisaligned = (nextPc[1:0] != 2'b00);

  // State register. pc_valid is registered from the next state, so it
  // depends on flops only and is 1 throughout reset.
  always_ff @(posedge clk_i or negedge rstSyncN) begin
    if (!rstSyncN) begin
      state_q       <= ISSUE;
      pc_q          <= RESET_PC;
      pcValid_q     <= 1'b1;
      excMisalign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pcValid_q     <= pcValid_d;
      excMisalign_q <= excMisalign_d;
    end
  end

  // Next-state logic. A misaligned target leaves pc untouched, so the
  // faulting instruction's PC stays visible while the unit is in HALT.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    excMisalign_d = excMisalign_q;
    case (state_q)
      ISSUE: begin
        if (fetchFire) state_d = WAIT;
      end
      WAIT: begin
        if (retireFire) begin
          if (nextMisaligned) begin
            state_d       = HALT;
            excMisalign_d = 1'b1;
          end else begin
            state_d = ISSUE;
            pc_d    = nextPc;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = ISSUE;
      end
    endcase
    pcValid_d = (state_d == ISSUE);
  end

  // Output logic
  always_comb begin
    pc_o           = pc_q;
    pc_valid_o     = pcValid_q;
    wbu_ready_o    = (state_q == WAIT);
    exc_misalign_o = excMisalign_q;
  end

`ifdef PCU_PERF_CNT_EN
  logic [63:0] retireCnt_q, retireCnt_d;

  // Counts every accepted retire, including the one that enters HALT.
  // The count cannot advance in HALT because wbu_ready is 0 there.
  always_comb begin
    retireCnt_d = retireCnt_q;
    if (retireFire) retireCnt_d = retireCnt_q + 64'd1;
  end

  always_ff @(posedge clk_i or negedge rstSyncN) begin
    if (!rstSyncN) begin
      retireCnt_q <= 64'd0;
    end else begin
      retireCnt_q <= retireCnt_d;
    end
  end

  assign retire_cnt_o = retireCnt_q;
`endif

endmodule

// File: tb/tb_ysyx_25030093_pcu.sv
// Testbench for ysyx_25030093_pcu. A transaction-level model (one
// outstanding PC, a halted flag, reset-release delay) is compared with the
// DUT on every falling edge. Directed literal checks pin the model, and a
// randomized phase follows them. A second instance with
// RESET_PC=FFFF_FFFC covers the pc+4 wraparound.

module tb_ysyx_25030093_pcu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifuReady = 1'b0;
  logic        wbuValid = 1'b0;
  logic        wbuJump = 1'b0;
  logic [31:0] wbuDnpc = 32'h0;
  logic [31:0] pc;
  logic        pcValid;
  logic        wbuReady;
  logic        excMisalign;

  logic        wIfuReady = 1'b0;
  logic        wWbuValid = 1'b0;
  logic [31:0] wPc;
  logic        wPcValid;
  logic        wWbuReady;
  logic        wExc;

`ifdef PCU_PERF_CNT_EN
  logic [63:0] retireCnt;
  logic [63:0] wRetireCnt;
`endif

  int checks = 0;
  int failures = 0;
  logic checkEn = 1'b0;

  always #5 clk = ~clk;

  ysyx_25030093_pcu #(.RESET_PC(RESET_PC)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .pc_o           (pc),
    .pc_valid_o     (pcValid),
    .ifu_ready_i    (ifuReady),
    .wbu_valid_i    (wbuValid),
    .wbu_ready_o    (wbuReady),
    .wbu_jump_i     (wbuJump),
    .wbu_dnpc_i     (wbuDnpc),
    .exc_misalign_o (excMisalign)
`ifdef PCU_PERF_CNT_EN
    ,
    .retire_cnt_o   (retireCnt)
`endif
  );

  ysyx_25030093_pcu #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .pc_o           (wPc),
    .pc_valid_o     (wPcValid),
    .ifu_ready_i    (wIfuReady),
    .wbu_valid_i    (wWbuValid),
    .wbu_ready_o    (wWbuReady),
    .wbu_jump_i     (1'b0),
    .wbu_dnpc_i     (32'h0),
    .exc_misalign_o (wExc)
`ifdef PCU_PERF_CNT_EN
    ,
    .retire_cnt_o   (wRetireCnt)
`endif
  );

  // Behavioural model: one PC may be outstanding (mBusy); a retire either
  // moves to the aligned target or halts; reset release costs two edges.
  logic        mBusy = 1'b0;
  logic        mHalted = 1'b0;
  logic [31:0] mPc = RESET_PC;
  logic        mExc = 1'b0;
  int          mHold = 2;
  logic [31:0] mTarget;
`ifdef PCU_PERF_CNT_EN
  logic [63:0] mCnt = 64'd0;
`endif

  assign mTarget = wbuJump ? wbuDnpc : (mPc + 32'd4);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy   <= 1'b0;
      mHalted <= 1'b0;
      mPc     <= RESET_PC;
      mExc    <= 1'b0;
      mHold   <= 2;
`ifdef PCU_PERF_CNT_EN
      mCnt    <= 64'd0;
`endif
    end else if (mHold > 0) begin
      mHold <= mHold - 1;
    end else if (!mHalted) begin
      if (!mBusy) begin
        if (ifuReady) mBusy <= 1'b1;
      end else if (wbuValid) begin
`ifdef PCU_PERF_CNT_EN
        mCnt <= mCnt + 64'd1;
`endif
        if (mTarget[1:0] != 2'b00) begin
          mHalted <= 1'b1;
          mExc    <= 1'b1;
        end else begin
          mPc   <= mTarget;
          mBusy <= 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_pc", {32'h0, pc}, {32'h0, mPc});
      checkOutput("model_pc_valid", {63'h0, pcValid}, {63'h0, !mBusy && !mHalted});
      checkOutput("model_wbu_ready", {63'h0, wbuReady}, {63'h0, mBusy && !mHalted});
      checkOutput("model_exc", {63'h0, excMisalign}, {63'h0, mExc});
`ifdef PCU_PERF_CNT_EN
      checkOutput("model_retire_cnt", retireCnt, mCnt);
`endif
    end
  end

  // Drive main-DUT inputs just after a falling edge, then run one cycle.
  task automatic applyStimulus(input logic ifu, input logic wv, input logic jmp, input logic [31:0] dn);
    ifuReady = ifu;
    wbuValid = wv;
    wbuJump  = jmp;
    wbuDnpc  = dn;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic doFetch();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic doRetire(input logic jmp, input logic [31:0] dn);
    applyStimulus(1'b0, 1'b1, jmp, dn);
  endtask

  task automatic releaseReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] dn;
    int waitCnt;

    repeat (3) @(negedge clk);
    #1;
    checkEn = 1'b1;

    // While reset is held: valid RESET_PC, no retire acceptance
    checkOutput("rst_pc", {32'h0, pc}, 64'h8000_0000);
    checkOutput("rst_pc_valid", {63'h0, pcValid}, 64'd1);
    checkOutput("rst_wbu_ready", {63'h0, wbuReady}, 64'd0);
    checkOutput("rst_exc", {63'h0, excMisalign}, 64'd0);

    // Release with ifu_ready already high; synchroniser delays the handshake
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("sync_still_issue", {63'h0, pcValid}, 64'd1);
    waitCnt = 0;
    while (!wbuReady && waitCnt < 6) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      waitCnt++;
    end
    checkOutput("first_fetch_wbu_ready", {63'h0, wbuReady}, 64'd1);
    checkOutput("first_fetch_pc", {32'h0, pc}, 64'h8000_0000);
    checkOutput("first_fetch_pc_valid", {63'h0, pcValid}, 64'd0);

    // Three sequential retires
    doRetire(1'b0, 32'h0);
    checkOutput("seq_pc1", {32'h0, pc}, 64'h8000_0004);
    checkOutput("seq_pc1_valid", {63'h0, pcValid}, 64'd1);
    doFetch();
    doRetire(1'b0, 32'h0);
    checkOutput("seq_pc2", {32'h0, pc}, 64'h8000_0008);
    doFetch();
    doRetire(1'b0, 32'h0);
    checkOutput("seq_pc3", {32'h0, pc}, 64'h8000_000C);
`ifdef PCU_PERF_CNT_EN
    checkOutput("seq_retire_cnt", retireCnt, 64'd3);
`endif

    // Redirect, then dnpc ignored without jump
    doFetch();
    doRetire(1'b1, 32'h8000_0100);
    checkOutput("redirect_pc", {32'h0, pc}, 64'h8000_0100);
    doFetch();
    doRetire(1'b0, 32'h1234_5678);
    checkOutput("nojump_pc", {32'h0, pc}, 64'h8000_0104);

    // wbu_valid held in ISSUE with ifu_ready low: nothing moves
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h8000_0200);
      checkOutput("stall_pc", {32'h0, pc}, 64'h8000_0104);
      checkOutput("stall_pc_valid", {63'h0, pcValid}, 64'd1);
    end

    // Reset asserted in WAIT returns pc asynchronously
    doFetch();
    checkOutput("wait_before_rst", {63'h0, wbuReady}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_pc", {32'h0, pc}, 64'h8000_0000);
    checkOutput("async_rst_pc_valid", {63'h0, pcValid}, 64'd1);
    checkOutput("async_rst_wbu_ready", {63'h0, wbuReady}, 64'd0);
    releaseReset();

    // Misaligned redirect halts
    doFetch();
    doRetire(1'b1, 32'h8000_0102);
    checkOutput("halt_pc_valid", {63'h0, pcValid}, 64'd0);
    checkOutput("halt_wbu_ready", {63'h0, wbuReady}, 64'd0);
    checkOutput("halt_exc", {63'h0, excMisalign}, 64'd1);
    checkOutput("halt_pc", {32'h0, pc}, 64'h8000_0000);
`ifdef PCU_PERF_CNT_EN
    checkOutput("halt_retire_cnt", retireCnt, 64'd1);
`endif
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 32'h8000_0200);
    checkOutput("halt_sticky_exc", {63'h0, excMisalign}, 64'd1);
    checkOutput("halt_sticky_pc", {32'h0, pc}, 64'h8000_0000);
    checkOutput("halt_sticky_valid", {63'h0, pcValid}, 64'd0);
`ifdef PCU_PERF_CNT_EN
    checkOutput("halt_frozen_cnt", retireCnt, 64'd1);
`endif
    rst_n = 1'b0;
    #1;
    checkOutput("halt_rst_exc", {63'h0, excMisalign}, 64'd0);
    checkOutput("halt_rst_pc_valid", {63'h0, pcValid}, 64'd1);
`ifdef PCU_PERF_CNT_EN
    checkOutput("halt_rst_cnt", retireCnt, 64'd0);
`endif
    releaseReset();

    // Wraparound instance: FFFF_FFFC + 4 -> 0 without a flag
    wIfuReady = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    wIfuReady = 1'b0;
    checkOutput("wrap_wbu_ready", {63'h0, wWbuReady}, 64'd1);
    checkOutput("wrap_pc_before", {32'h0, wPc}, 64'hFFFF_FFFC);
    wWbuValid = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    wWbuValid = 1'b0;
    checkOutput("wrap_pc_after", {32'h0, wPc}, 64'h0);
    checkOutput("wrap_exc", {63'h0, wExc}, 64'd0);
    checkOutput("wrap_pc_valid", {63'h0, wPcValid}, 64'd1);

    // Randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ((mHalted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
      end
      dn = mPc + (32'($urandom_range(0, 63)) * 32'd4);
      if ($urandom_range(0, 11) == 0) dn[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) dn = 32'hFFFF_FFFC;
      applyStimulus(1'($urandom % 2), 1'($urandom % 2), 1'($urandom_range(0, 3) == 0), dn);
    end

    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
